// File: rtl/synth_poly_pwm.sv
// Polyphonic square-wave synth: per-channel tone dividers with attack/release envelopes,
// an additive mixer and a single-bit PWM DAC with a one-cycle delayed copy.
`timescale 1ns/1ps
module synth_poly_pwm #(
  parameter int unsigned NNOTES    = 5,
  parameter logic [15:0] HALF_BASE = 16'd1000,
  parameter logic [15:0] HALF_STEP = 16'd100,
  parameter int unsigned ENV_W     = 4,
  parameter int unsigned ENV_TICK  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NNOTES-1:0] note_en,
  input  logic [7:0]        sw,
  output logic              pwm_out,
  output logic              pwm_out_d,
  output logic              active
);
  localparam int unsigned MIX_W = ENV_W + $clog2(NNOTES + 1);
  localparam int unsigned PRE_W = (ENV_TICK > 1) ? $clog2(ENV_TICK) : 1;
  localparam logic [ENV_W-1:0] LEVEL_MAX = {ENV_W{1'b1}};
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(ENV_TICK - 1);

  logic [1:0] shift;
  logic       mute;
  logic [4:0] unused_sw;

  assign shift     = sw[1:0];
  assign mute      = sw[2];
  assign unused_sw = sw[7:3];

  logic [NNOTES-1:0][15:0]      half;
  logic [NNOTES-1:0][15:0]      div_q, div_d;
  logic [NNOTES-1:0]            sq_q, sq_d;
  logic [NNOTES-1:0][ENV_W-1:0] level_q, level_d;
  logic [PRE_W-1:0]             pre_q, pre_d;
  logic                         env_step;
  logic [MIX_W-1:0]             mix, pcnt_q, sample_q, sample_eff;

  // Tone dividers. The >= test lets a half-period that shrank mid-count wrap on the next
  // cycle instead of running the counter all the way round.
  always_comb begin
    half  = '0;
    div_d = div_q;
    sq_d  = sq_q;
    for (int i = 0; i < NNOTES; i++) begin
      half[i] = (HALF_BASE - 16'(i) * HALF_STEP) >> shift;
      if (({1'b0, div_q[i]} + 17'd1) >= {1'b0, half[i]}) begin
        div_d[i] = '0;
        sq_d[i]  = ~sq_q[i];
      end else begin
        div_d[i] = div_q[i] + 16'd1;
      end
    end
  end

  assign env_step = (pre_q == PRE_LAST);
  assign pre_d    = env_step ? '0 : pre_q + PRE_W'(1);

  // Envelopes only move on the shared tick, so gate changes wait for the next step.
  always_comb begin
    level_d = level_q;
    if (env_step) begin
      for (int i = 0; i < NNOTES; i++) begin
        if (note_en[i] && (level_q[i] != LEVEL_MAX)) begin
          level_d[i] = level_q[i] + ENV_W'(1);
        end else if (!note_en[i] && (level_q[i] != '0)) begin
          level_d[i] = level_q[i] - ENV_W'(1);
        end
      end
    end
  end

  always_comb begin
    mix = '0;
    for (int i = 0; i < NNOTES; i++) begin
      if (sq_q[i]) begin
        mix = mix + MIX_W'(level_q[i]);
      end
    end
    if (mute) begin
      mix = '0;
    end
  end

  // The value latched at counter 0 also drives that cycle's compare, so each PWM period
  // is produced entirely from one sample.
  assign sample_eff = (pcnt_q == '0) ? mix : sample_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      sq_q      <= '0;
      level_q   <= '0;
      pre_q     <= '0;
      pcnt_q    <= '0;
      sample_q  <= '0;
      pwm_out   <= 1'b0;
      pwm_out_d <= 1'b0;
      active    <= 1'b0;
    end else begin
      div_q     <= div_d;
      sq_q      <= sq_d;
      level_q   <= level_d;
      pre_q     <= pre_d;
      pcnt_q    <= pcnt_q + MIX_W'(1);
      sample_q  <= sample_eff;
      pwm_out   <= (pcnt_q < sample_eff);
      pwm_out_d <= pwm_out;
      active    <= |level_q;
    end
  end

endmodule

// File: tb/tb_synth_poly_pwm.sv
// Bench for synth_poly_pwm: directed scenarios plus randomised gates/switches, all checked
// against an integer behavioural model of tones, envelopes, mixer and PWM period.
`timescale 1ns/1ps
module tb_synth_poly_pwm;
  localparam int NN   = 2;
  localparam int HB   = 8;
  localparam int HS   = 4;
  localparam int ET   = 4;
  localparam int LMAX = 15;
  localparam int PPER = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] note_en = '0;
  logic [7:0] sw = '0;
  logic       pwm_out, pwm_out_d, active;

  int checks = 0;
  int errors = 0;

  synth_poly_pwm #(
    .NNOTES   (NN),
    .HALF_BASE(16'd8),
    .HALF_STEP(16'd4),
    .ENV_W    (4),
    .ENV_TICK (ET)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .note_en  (note_en),
    .sw       (sw),
    .pwm_out  (pwm_out),
    .pwm_out_d(pwm_out_d),
    .active   (active)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Behavioural model state (plain integers).
  int m_div[NN];
  int m_sq[NN];
  int m_lvl[NN];
  int m_pre, m_pcnt, m_sample, m_pwm, m_pwm_d, m_act;

  function automatic logic [1:0] m_sq_vec();
    return {m_sq[1][0], m_sq[0][0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NN; i++) begin
      m_div[i] = 0;
      m_sq[i]  = 0;
      m_lvl[i] = 0;
    end
    m_pre = 0; m_pcnt = 0; m_sample = 0; m_pwm = 0; m_pwm_d = 0; m_act = 0;
  endtask

  // One clock: the model consumes the inputs the DUT saw at this edge; outputs sampled 1ns later.
  task automatic step();
    int mix, any_lvl, tick, p;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      mix = 0;
      any_lvl = 0;
      for (int i = 0; i < NN; i++) begin
        if (m_sq[i] != 0) mix += m_lvl[i];
        if (m_lvl[i] > 0) any_lvl = 1;
      end
      if (sw[2]) mix = 0;
      tick = (m_pre == ET - 1) ? 1 : 0;
      m_pwm_d = m_pwm;
      if (m_pcnt == 0) m_sample = mix;
      m_pwm  = (m_pcnt < m_sample) ? 1 : 0;
      m_pcnt = (m_pcnt + 1) % PPER;
      m_pre  = (m_pre + 1) % ET;
      m_act  = any_lvl;
      for (int i = 0; i < NN; i++) begin
        p = (HB - i * HS) >> sw[1:0];
        if (m_div[i] + 1 >= p) begin
          m_div[i] = 0;
          m_sq[i]  = 1 - m_sq[i];
        end else begin
          m_div[i] = m_div[i] + 1;
        end
        if (tick != 0) begin
          if (note_en[i]) m_lvl[i] = (m_lvl[i] < LMAX) ? m_lvl[i] + 1 : LMAX;
          else            m_lvl[i] = (m_lvl[i] > 0) ? m_lvl[i] - 1 : 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; note_en = '0; sw = '0;
    repeat (3) step();
    checks++; if (pwm_out !== 1'b0)
      begin errors++; $display("FAIL reset_pwm_out: got %b want 0", pwm_out); end
    checks++; if (pwm_out_d !== 1'b0)
      begin errors++; $display("FAIL reset_pwm_out_d: got %b want 0", pwm_out_d); end
    checks++; if (active !== 1'b0)
      begin errors++; $display("FAIL reset_active: got %b want 0", active); end
    checks++; if (dut.sq_q !== 2'b00)
      begin errors++; $display("FAIL reset_sq: got %b want 00", dut.sq_q); end
    checks++; if (dut.level_q !== 8'h00)
      begin errors++; $display("FAIL reset_level: got %h want 00", dut.level_q); end
    checks++; if (dut.pcnt_q !== 6'd0)
      begin errors++; $display("FAIL reset_pcnt: got %0d want 0", dut.pcnt_q); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int last_rise[2] = '{-1, -1};
    int period[2] = '{-1, -1};
    logic [1:0] prev_sq;
    prev_sq = dut.sq_q;
    for (int c = 1; c <= 200; c++) begin
      step();
      checks++; if ({pwm_out, pwm_out_d, active} !== 3'b000) begin
        errors++; $display("FAIL idle_outputs c=%0d: got %b want 000", c,
                           {pwm_out, pwm_out_d, active});
      end
      checks++; if (dut.sq_q !== m_sq_vec()) begin
        errors++; $display("FAIL idle_sq c=%0d: got %b want %b", c, dut.sq_q, m_sq_vec());
      end
      for (int i = 0; i < 2; i++) begin
        if (dut.sq_q[i] === 1'b1 && prev_sq[i] === 1'b0) begin
          if (last_rise[i] >= 0) period[i] = c - last_rise[i];
          last_rise[i] = c;
        end
      end
      prev_sq = dut.sq_q;
    end
    checks++; if (period[0] !== 16)
      begin errors++; $display("FAIL idle_sq0_period: got %0d want 16", period[0]); end
    checks++; if (period[1] !== 8)
      begin errors++; $display("FAIL idle_sq1_period: got %0d want 8", period[1]); end
  endtask

  task automatic test_attack();
    int exp_l;
    rst = 1'b1; step(); rst = 1'b0;
    note_en = 2'b01; sw = '0;
    for (int c = 1; c <= 70; c++) begin
      step();
      exp_l = (c / 4 > LMAX) ? LMAX : c / 4;
      checks++; if (dut.level_q[0] !== 4'(exp_l)) begin
        errors++; $display("FAIL attack_level0 c=%0d: got %0d want %0d", c, dut.level_q[0], exp_l);
      end
      checks++; if (active !== (c >= 5)) begin
        errors++; $display("FAIL attack_active c=%0d: got %b want %b", c, active, c >= 5);
      end
      checks++; if (dut.level_q[1] !== 4'd0) begin
        errors++; $display("FAIL attack_level1 c=%0d: got %0d want 0", c, dut.level_q[1]);
      end
    end
  endtask

  task automatic test_duty();
    int found = 0, highs = 0, highs_d = 0;
    // Nudge the tone phase with a brief octave shift until a latch sees sq_0 = 1.
    for (int a = 0; a < 32 && found == 0; a++) begin
      sw = 8'd1; repeat ($urandom_range(1, 7)) step(); sw = 8'd0;
      for (int w = 0; w < PPER && found == 0; w++) begin
        if (m_pcnt == 0 && m_sq[0] != 0) found = 1;
        else step();
      end
    end
    checks++; if (found == 0)
      begin errors++; $display("FAIL duty_latch_search: got timeout want latch with sq_0=1"); end
    checks++; if (dut.level_q[0] !== 4'd15)
      begin errors++; $display("FAIL duty_level0: got %0d want 15", dut.level_q[0]); end
    for (int c = 0; c <= PPER; c++) begin
      step();
      if (c < PPER) highs += int'(pwm_out);
      if (c > 0) highs_d += int'(pwm_out_d);
      checks++; if (pwm_out !== m_pwm[0]) begin
        errors++; $display("FAIL duty_pwm c=%0d: got %b want %b", c, pwm_out, m_pwm[0]);
      end
    end
    checks++; if (highs !== 15)
      begin errors++; $display("FAIL duty_high_count: got %0d want 15", highs); end
    checks++; if (highs_d !== 15)
      begin errors++; $display("FAIL duty_d_high_count: got %0d want 15", highs_d); end
  endtask

  task automatic test_mute();
    int found = 0, highs = 0;
    note_en = 2'b11; sw = '0;
    repeat (70) step();
    checks++; if (dut.level_q !== 8'hff)
      begin errors++; $display("FAIL mute_levels: got %h want ff", dut.level_q); end
    for (int a = 0; a < 48 && found == 0; a++) begin
      sw = 8'd1; repeat ($urandom_range(1, 7)) step(); sw = 8'd0;
      for (int w = 0; w < PPER && found == 0; w++) begin
        if (m_pcnt == 0 && m_sq[0] != 0 && m_sq[1] != 0) found = 1;
        else step();
      end
    end
    checks++; if (found == 0)
      begin errors++; $display("FAIL mute_latch_search: got timeout want latch with sq=11"); end
    step();
    checks++; if (dut.sample_q !== 6'd30)
      begin errors++; $display("FAIL mute_sample30: got %0d want 30", dut.sample_q); end
    highs = int'(pwm_out);
    sw = 8'h04;
    for (int c = 1; c < PPER; c++) begin
      step();
      highs += int'(pwm_out);
    end
    checks++; if (highs !== 30)
      begin errors++; $display("FAIL mute_high_count: got %0d want 30", highs); end
    for (int c = 0; c < PPER; c++) begin
      step();
      checks++; if (pwm_out !== 1'b0)
        begin errors++; $display("FAIL mute_pwm_low c=%0d: got %b want 0", c, pwm_out); end
    end
    checks++; if (dut.sample_q !== 6'd0)
      begin errors++; $display("FAIL mute_sample0: got %0d want 0", dut.sample_q); end
    sw = '0;
  endtask

  task automatic test_shift();
    int found = 0, toggles = 0;
    logic exp_sq, prev;
    sw = '0;
    for (int w = 0; w < 40 && found == 0; w++) begin
      step();
      if (m_div[0] == 5) found = 1;
    end
    checks++; if (dut.div_q[0] !== 16'd5)
      begin errors++; $display("FAIL shift_precount: got %0d want 5", dut.div_q[0]); end
    exp_sq = (m_sq[0] != 0) ? 1'b0 : 1'b1;
    sw = 8'd2;
    step();
    checks++; if (dut.div_q[0] !== 16'd0)
      begin errors++; $display("FAIL shift_clear: got %0d want 0", dut.div_q[0]); end
    checks++; if (dut.sq_q[0] !== exp_sq)
      begin errors++; $display("FAIL shift_toggle: got %b want %b", dut.sq_q[0], exp_sq); end
    prev = dut.sq_q[0];
    for (int c = 0; c < 8; c++) begin
      step();
      if (dut.sq_q[0] !== prev) toggles++;
      prev = dut.sq_q[0];
    end
    checks++; if (toggles !== 4)
      begin errors++; $display("FAIL shift_toggle_rate: got %0d want 4", toggles); end
    sw = '0;
  endtask

  task automatic test_reset_mid();
    sw = '0; note_en = 2'b01;
    rst = 1'b1; step(); rst = 1'b0;
    for (int w = 0; w < 100 && m_lvl[0] != 7; w++) step();
    checks++; if (dut.level_q[0] !== 4'd7)
      begin errors++; $display("FAIL rmid_level7: got %0d want 7", dut.level_q[0]); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if ({pwm_out, pwm_out_d, active} !== 3'b000) begin
      errors++; $display("FAIL rmid_outputs: got %b want 000", {pwm_out, pwm_out_d, active});
    end
    checks++; if ({dut.level_q, dut.sq_q, dut.div_q[0], dut.div_q[1]} !== 42'd0)
      begin errors++; $display("FAIL rmid_core_state: got nonzero want all zero"); end
    checks++; if ({dut.pcnt_q, dut.sample_q, dut.pre_q} !== 14'd0)
      begin errors++; $display("FAIL rmid_pwm_state: got nonzero want all zero"); end
    repeat (64) step();
    checks++; if (dut.level_q[0] !== 4'd15)
      begin errors++; $display("FAIL rmid_level15: got %0d want 15", dut.level_q[0]); end
    for (int w = 0; w < 8 && m_pre != 0; w++) step();
    note_en = 2'b00;
    for (int c = 1; c <= 64; c++) begin
      step();
      if (c == 59) begin
        checks++; if (dut.level_q[0] !== 4'd1)
          begin errors++; $display("FAIL release_c59: got %0d want 1", dut.level_q[0]); end
      end
      if (c == 60) begin
        checks++; if ({dut.level_q[0], active} !== 5'b0000_1) begin
          errors++; $display("FAIL release_c60: got lvl=%0d act=%b want lvl=0 act=1",
                             dut.level_q[0], active);
        end
      end
      if (c == 61) begin
        checks++; if (active !== 1'b0)
          begin errors++; $display("FAIL release_active_fall: got %b want 0", active); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) note_en = 2'($urandom);
      if ($urandom_range(0, 31) == 0) sw = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step();
      checks++; if ({pwm_out, pwm_out_d, active} !== {m_pwm[0], m_pwm_d[0], m_act[0]}) begin
        errors++; $display("FAIL rand_outputs c=%0d: got %b want %b", c,
                           {pwm_out, pwm_out_d, active}, {m_pwm[0], m_pwm_d[0], m_act[0]});
      end
      checks++; if (dut.sq_q !== m_sq_vec()) begin
        errors++; $display("FAIL rand_sq c=%0d: got %b want %b", c, dut.sq_q, m_sq_vec());
      end
      checks++; if (dut.level_q !== {4'(m_lvl[1]), 4'(m_lvl[0])}) begin
        errors++; $display("FAIL rand_levels c=%0d: got %h want %h", c, dut.level_q,
                           {4'(m_lvl[1]), 4'(m_lvl[0])});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_idle();
    test_attack();
    test_duty();
    test_mute();
    test_shift();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
